// File: rtl/systolic_pkg.sv
// Shared encodings for the systolic array sequencer: FSM states, array
// instruction codes and a small sizing helper.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GAP,
        EXEC,
        DRAIN,
        DONE
    } state_e;

    localparam logic [1:0] INST_IDLE = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;
    localparam logic [1:0] INST_OSEX = 2'b11;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// Host-facing bundle of the sequencer: start/config/stall in, SRAM strobes,
// array instructions, FIFO write and clock-enable requests out.
interface systolic_seq_ctrl_if #(
    parameter int MAX_INP = 256,
    parameter int MAX_KIJ = 16,
    parameter int WADDR_W = 11,
    parameter int IADDR_W = 8
);
    logic                           start;
    logic                           os_mode;
    logic [$clog2(MAX_INP+1)-1:0]   cfg_inp;
    logic [$clog2(MAX_KIJ+1)-1:0]   cfg_kij;
    logic                           stall;
    logic                           busy;
    logic                           done;
    logic [$clog2(MAX_KIJ)-1:0]     kij_idx;
    logic                           w_rd;
    logic [WADDR_W-1:0]             w_addr;
    logic                           i_rd;
    logic [IADDR_W-1:0]             i_addr;
    logic [1:0]                     inst_w;
    logic                           mode;
    logic                           ofifo_wr;
    logic                           w_ce;
    logic                           i_ce;

    modport master (
        input  start, os_mode, cfg_inp, cfg_kij, stall,
        output busy, done, kij_idx, w_rd, w_addr, i_rd, i_addr,
               inst_w, mode, ofifo_wr, w_ce, i_ce
    );

    modport slave (
        output start, os_mode, cfg_inp, cfg_kij, stall,
        input  busy, done, kij_idx, w_rd, w_addr, i_rd, i_addr,
               inst_w, mode, ofifo_wr, w_ce, i_ce
    );
endinterface

// File: rtl/systolic_seq_ctrl_delay_line.sv
// Fixed-depth 1-bit delay line with synchronous reset; q is d delayed by
// DEPTH clocks.
module delay_line #(
    parameter int DEPTH = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [DEPTH-1:0] vld_pipe;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= d;
            for (int k = 1; k < DEPTH; k++) vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    assign q = vld_pipe[DEPTH-1];
endmodule

// File: rtl/systolic_seq_ctrl.sv
// Convolution-pass sequencer for the systolic MAC array. Outputs are
// registered from the next-state decode so they line up with the state.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int ROW     = 8,
    parameter int COL     = 8,
    parameter int MAX_INP = 256,
    parameter int MAX_KIJ = 16,
    parameter int WADDR_W = 11,
    parameter int IADDR_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    systolic_seq_ctrl_if.master bus
);
    localparam int DRAIN_LEN = ROW + COL - 1;
    localparam int CNT_W     = $clog2(max3(ROW, MAX_INP, DRAIN_LEN));
    localparam int IDX_W     = $clog2(MAX_KIJ);
    localparam int INP_W     = $clog2(MAX_INP + 1);
    localparam int KIJ_W     = $clog2(MAX_KIJ + 1);
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(ROW - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_LEN - 1);

    state_e             state, ns;
    logic [CNT_W-1:0]   cnt, ncnt, inp_last, inp_last_n;
    logic [IDX_W-1:0]   kij, nkij, kij_last, kij_last_n;
    logic               os_q, os_n, nbub, issue, wrap_soon;
    logic               nw_rd, ni_rd, nw_ce, ni_ce;
    logic [1:0]         ninst;
    logic [WADDR_W-1:0] ws_addr, os_addr;

    logic               busy_q, done_q, w_rd_q, i_rd_q, mode_q, w_ce_q, i_ce_q, ofifo_q;
    logic [1:0]         inst_q;
    logic [WADDR_W-1:0] w_addr_q;
    logic [IADDR_W-1:0] i_addr_q;

    // zero lengths run once, oversize lengths clamp to the maximum
    always_comb begin
        inp_last_n = '0;
        kij_last_n = '0;
        if (bus.cfg_inp > INP_W'(MAX_INP))  inp_last_n = CNT_W'(MAX_INP - 1);
        else if (bus.cfg_inp != '0)         inp_last_n = CNT_W'(bus.cfg_inp - 1'b1);
        if (bus.cfg_kij > KIJ_W'(MAX_KIJ))  kij_last_n = IDX_W'(MAX_KIJ - 1);
        else if (bus.cfg_kij != '0)         kij_last_n = IDX_W'(bus.cfg_kij - 1'b1);
    end

    always_comb begin
        ns    = state;
        ncnt  = cnt;
        nkij  = kij;
        nbub  = 1'b0;
        os_n  = (state == IDLE) ? bus.os_mode : os_q;
        unique case (state)
            IDLE: if (bus.start) begin
                ncnt = '0;
                nkij = '0;
                ns   = bus.os_mode ? EXEC : LOAD;
            end
            LOAD: if (cnt == LOAD_LAST) begin
                ns   = GAP;
                ncnt = '0;
            end else ncnt = cnt + 1'b1;
            GAP: begin
                ns   = EXEC;
                ncnt = '0;
            end
            EXEC: if (bus.stall) nbub = 1'b1;
            else if (cnt == inp_last) begin
                ns   = DRAIN;
                ncnt = '0;
            end else ncnt = cnt + 1'b1;
            DRAIN: if (cnt == DRAIN_LAST) begin
                ncnt = '0;
                if (kij == kij_last) ns = DONE;
                else begin
                    nkij = kij + 1'b1;
                    ns   = os_q ? EXEC : LOAD;
                end
            end else ncnt = cnt + 1'b1;
            DONE: ns = IDLE;
            default: ns = IDLE;
        endcase

        issue     = (ns == EXEC) && !nbub;
        // last drain cycle before another position: reads start next cycle
        wrap_soon = (ns == DRAIN) && (ncnt == DRAIN_LAST) && (nkij != kij_last);
        nw_rd     = (ns == LOAD) || (issue && os_n);
        ni_rd     = issue;
        nw_ce     = (ns == LOAD) || ((ns == EXEC) && os_n) || wrap_soon;
        ni_ce     = (ns == GAP) || (ns == EXEC) || (wrap_soon && os_n);
        ninst     = INST_IDLE;
        if (ns == LOAD || ns == GAP) ninst = INST_LOAD;
        else if (issue)              ninst = os_n ? INST_OSEX : INST_EXEC;
        ws_addr   = WADDR_W'(nkij) * WADDR_W'(ROW) + WADDR_W'(ncnt);
        os_addr   = WADDR_W'(nkij) * WADDR_W'(MAX_INP) + WADDR_W'(ncnt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            kij      <= '0;
            os_q     <= 1'b0;
            inp_last <= '0;
            kij_last <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            w_rd_q   <= 1'b0;
            i_rd_q   <= 1'b0;
            mode_q   <= 1'b0;
            w_ce_q   <= 1'b0;
            i_ce_q   <= 1'b0;
            inst_q   <= INST_IDLE;
            w_addr_q <= '0;
            i_addr_q <= '0;
        end else begin
            state  <= ns;
            cnt    <= ncnt;
            kij    <= nkij;
            if (state == IDLE && bus.start) begin
                os_q     <= bus.os_mode;
                inp_last <= inp_last_n;
                kij_last <= kij_last_n;
            end
            busy_q <= (ns != IDLE);
            done_q <= (ns == DONE);
            w_rd_q <= nw_rd;
            i_rd_q <= ni_rd;
            mode_q <= (ns == EXEC);
            w_ce_q <= nw_ce;
            i_ce_q <= ni_ce;
            inst_q <= ninst;
            if (nw_rd) w_addr_q <= (ns == LOAD) ? ws_addr : os_addr;
            if (ni_rd) i_addr_q <= IADDR_W'(ncnt);
        end
    end

    delay_line #(.DEPTH(DRAIN_LEN)) u_ofifo_dly (
        .clk   (clk),
        .reset (reset),
        .d     (i_rd_q),
        .q     (ofifo_q)
    );

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.kij_idx  = kij;
    assign bus.w_rd     = w_rd_q;
    assign bus.w_addr   = w_addr_q;
    assign bus.i_rd     = i_rd_q;
    assign bus.i_addr   = i_addr_q;
    assign bus.inst_w   = inst_q;
    assign bus.mode     = mode_q;
    assign bus.ofifo_wr = ofifo_q;
    assign bus.w_ce     = w_ce_q;
    assign bus.i_ce     = i_ce_q;
endmodule
